spi_stream_feeder: RTL and testbench

- Upstream stage of the SPI master. Accepts an MP3 byte stream on a valid/ready interface and buffers it in an internal FIFO.
- Pushes the bytes to the audio decoder by driving the SPI master's register port directly: it polls status, writes tx data and drains rx data.
- Paces transfers with the decoder's DREQ line, sending up to BURST bytes for each DREQ sample seen high.
- Sits between the SD/DMA byte source and the SPI master in the player SoC.

---
 rtl/spi_stream_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_stream_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_feeder.sv
// Buffers an MP3 byte stream in a small FIFO and feeds it to the decoder through
// the SPI master's register port, paced by the decoder's DREQ line.
module spi_stream_feeder #(
    parameter int FIFO_AW    = 4,
    parameter int BURST      = 32,
    parameter bit DISCARD_RX = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    input  logic               dreq,
    output logic               spi_select,
    output logic               read_n,
    output logic               write_n,
    output logic [2:0]         mem_addr,
    output logic [15:0]        data_to_spi,
    input  logic [15:0]        data_from_spi,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [31:0]        bytes_sent
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_POLL      = 3'd1;
    localparam logic [2:0] ST_POLL_GAP  = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_DRAIN_GAP = 3'd5;
    localparam logic [2:0] ST_WR        = 3'd6;
    localparam logic [2:0] ST_WR_GAP    = 3'd7;

    localparam logic [2:0] ADDR_RXDATA = 3'd0;
    localparam logic [2:0] ADDR_TXDATA = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               push;
    logic               pop;

    logic               dreq_meta;
    logic               dreq_sync;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic               phase;
    logic               access_now;
    logic [7:0]         burst_cnt;
    logic               status_trdy;
    logic               status_rrdy;
    logic [31:0]        sent_cnt;

    logic               nxt_rd;
    logic               nxt_wr;
    logic [2:0]         nxt_addr;

    // Rx data is only read to clear RRDY; the other status bits carry nothing we act on.
    logic               unused_status_bits;
    assign unused_status_bits = ^{data_from_spi[15:8], data_from_spi[5:0]};

    assign s_ready    = (level != FULL_LEVEL);
    assign push       = s_valid && s_ready;
    assign pop        = (state == ST_WR) && phase;
    assign fifo_level = level;
    assign bytes_sent = sent_cnt;
    assign busy       = (state != ST_IDLE);
    assign access_now = (state == ST_POLL) || (state == ST_DRAIN) || (state == ST_WR);

    // NOTE: FIFO storage has no reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dreq_meta <= 1'b0;
            dreq_sync <= 1'b0;
        end else begin
            dreq_meta <= dreq;
            dreq_sync <= dreq_meta;
        end
    end

    always_comb begin
        // NOTE: a default assignment up front keeps every path defined, so no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && (level != '0) && dreq_sync) begin
                    state_nxt = ST_POLL;
                end
            end
            ST_POLL:     if (phase) state_nxt = ST_POLL_GAP;
            ST_POLL_GAP: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (status_rrdy && DISCARD_RX) begin
                    state_nxt = ST_DRAIN;
                end else if (status_trdy) begin
                    state_nxt = ST_WR;
                end else begin
                    state_nxt = ST_POLL;
                end
            end
            ST_DRAIN:     if (phase) state_nxt = ST_DRAIN_GAP;
            ST_DRAIN_GAP: state_nxt = enable ? ST_POLL : ST_IDLE;
            ST_WR:        if (phase) state_nxt = ST_WR_GAP;
            ST_WR_GAP: begin
                if ((burst_cnt == 8'd0) || (level == '0) || !enable) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_POLL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign nxt_rd = (state_nxt == ST_POLL) || (state_nxt == ST_DRAIN);
    assign nxt_wr = (state_nxt == ST_WR);

    always_comb begin
        nxt_addr = ADDR_RXDATA;
        if (state_nxt == ST_POLL) begin
            nxt_addr = ADDR_STATUS;
        end else if (state_nxt == ST_WR) begin
            nxt_addr = ADDR_TXDATA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            burst_cnt   <= 8'd0;
            status_trdy <= 1'b0;
            status_rrdy <= 1'b0;
            sent_cnt    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            state <= state_nxt;
            phase <= access_now && !phase;
            if ((state == ST_IDLE) && (state_nxt == ST_POLL)) begin
                burst_cnt <= 8'(BURST);
            end else if (pop) begin
                burst_cnt <= burst_cnt - 8'd1;
            end
            if (pop) begin
                sent_cnt <= sent_cnt + 32'd1;
            end
            if ((state == ST_POLL) && phase) begin
                status_rrdy <= data_from_spi[7];
                status_trdy <= data_from_spi[6];
            end
        end
    end

    // Port signals are registered from the next state so strobes never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_select  <= 1'b0;
            read_n      <= 1'b1;
            write_n     <= 1'b1;
            mem_addr    <= ADDR_RXDATA;
            data_to_spi <= 16'h0000;
        end else begin
            spi_select  <= nxt_rd || nxt_wr;
            read_n      <= !nxt_rd;
            write_n     <= !nxt_wr;
            mem_addr    <= nxt_addr;
            data_to_spi <= nxt_wr ? {8'h00, mem[rd_ptr]} : 16'h0000;
        end
    end

endmodule

// File: tb/tb_spi_stream_feeder.sv
// Directed bench for spi_stream_feeder with a small SPI-master register model,
// an in-order byte scoreboard and an access-protocol monitor.
module tb_spi_stream_feeder;

    localparam int FIFO_AW = 4;
    localparam int BURST   = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_ready;
    logic               dreq;
    logic               spi_select;
    logic               read_n;
    logic               write_n;
    logic [2:0]         mem_addr;
    logic [15:0]        data_to_spi;
    logic [15:0]        data_from_spi;
    logic               busy;
    logic [FIFO_AW:0]   fifo_level;
    logic [31:0]        bytes_sent;

    always #5 clk = ~clk;

    spi_stream_feeder #(
        .FIFO_AW   (FIFO_AW),
        .BURST     (BURST),
        .DISCARD_RX(1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .dreq         (dreq),
        .spi_select   (spi_select),
        .read_n       (read_n),
        .write_n      (write_n),
        .mem_addr     (mem_addr),
        .data_to_spi  (data_to_spi),
        .data_from_spi(data_from_spi),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .bytes_sent   (bytes_sent)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Stimulus-owned model controls
    logic       rx_mode     = 1'b0;
    int         stall_until = 0;
    logic [7:0] exp_mem [256];
    logic [7:0] exp_wr      = 8'd0;

    // Monitor-owned model state
    logic        rrdy       = 1'b0;
    logic        roe        = 1'b0;
    logic        last_trdy  = 1'b0;
    int          poll_cnt   = 0;
    int          drain_cnt  = 0;
    int          wr_cnt     = 0;
    int          acc_starts = 0;
    int          proto_err  = 0;
    int          data_err   = 0;
    int          run        = 0;
    logic        idle_bad   = 1'b0;
    logic [2:0]  a_addr     = 3'd0;
    logic        a_rd       = 1'b0;
    logic        a_wr       = 1'b0;
    logic        a_ok       = 1'b0;
    logic [15:0] a_data     = 16'h0000;
    logic [7:0]  exp_rd     = 8'd0;

    logic model_trdy;
    assign model_trdy = (poll_cnt >= stall_until);

    always_comb begin
        data_from_spi = 16'h0000;
        case (mem_addr)
            3'd2:    data_from_spi = {8'h00, rrdy, model_trdy, 6'b000000};
            3'd0:    data_from_spi = 16'h005A;
            default: data_from_spi = 16'h0000;
        endcase
    end

    // An access is judged and applied to the model on the first idle negedge after it.
    always @(negedge clk) begin
        if (!reset_n) begin
            run      <= 0;
            idle_bad <= 1'b0;
            rrdy     <= 1'b0;
            exp_rd   <= exp_wr;
        end else if (spi_select) begin
            run <= run + 1;
            if (run == 0) begin
                a_addr     <= mem_addr;
                a_rd       <= !read_n;
                a_wr       <= !write_n;
                a_data     <= data_to_spi;
                a_ok       <= read_n ^ write_n;
                acc_starts <= acc_starts + 1;
                proto_err  <= proto_err + int'(idle_bad);
                idle_bad   <= 1'b0;
            end else if ((mem_addr != a_addr) || (read_n == a_rd) ||
                         (write_n == a_wr) || (data_to_spi != a_data)) begin
                a_ok <= 1'b0;
            end
        end else begin
            if (!read_n || !write_n) idle_bad <= 1'b1;
            if (!rx_mode) rrdy <= 1'b0;
            if (run != 0) begin
                run       <= 0;
                proto_err <= proto_err + int'(run != 2) + int'(!a_ok)
                           + int'(a_wr && !last_trdy)
                           + int'(!((a_rd && a_addr == 3'd2) || (a_rd && a_addr == 3'd0) ||
                                    (a_wr && a_addr == 3'd1)));
                if (a_rd && a_addr == 3'd2) begin
                    poll_cnt  <= poll_cnt + 1;
                    last_trdy <= model_trdy;
                end else if (a_rd && a_addr == 3'd0) begin
                    drain_cnt <= drain_cnt + 1;
                    rrdy      <= 1'b0;
                end else if (a_wr && a_addr == 3'd1) begin
                    wr_cnt    <= wr_cnt + 1;
                    last_trdy <= 1'b0;
                    data_err  <= data_err + int'(a_data != {8'h00, exp_mem[exp_rd]});
                    exp_rd    <= exp_rd + 8'd1;
                    if (rrdy) roe <= 1'b1;
                    if (rx_mode) rrdy <= 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        exp_mem[exp_wr] = b;
        exp_wr = exp_wr + 8'd1;
        cycles(1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while (wr_cnt < target && n < 2000) begin
            cycles(1);
            n++;
        end
        check({tag, "_write_timeout"}, wr_cnt >= target, 1'b1);
    endtask

    task automatic wait_polls(input int target, input string tag);
        int n = 0;
        while (poll_cnt < target && n < 2000) begin
            cycles(1);
            n++;
        end
        check({tag, "_poll_timeout"}, poll_cnt >= target, 1'b1);
    endtask

    task automatic wait_busy(input logic val, input string tag);
        int n = 0;
        while (busy !== val && n < 2000) begin
            cycles(1);
            n++;
        end
        check({tag, "_busy_timeout"}, busy, val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0, d0, a0;

        reset_n = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        dreq    = 1'b0;
        cycles(3);
        check("rst_spi_select", spi_select, 1'b0);
        check("rst_read_n", read_n, 1'b1);
        check("rst_write_n", write_n, 1'b1);
        check("rst_mem_addr", mem_addr, 3'd0);
        check("rst_data_to_spi", data_to_spi, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_level", fifo_level, 5'd0);
        check("rst_bytes_sent", bytes_sent, 32'd0);
        check("rst_s_ready", s_ready, 1'b1);
        reset_n = 1'b1;
        cycles(2);

        // Four bytes, one burst
        dreq = 1'b1;
        cycles(3);
        p0 = poll_cnt;
        w0 = wr_cnt;
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        push_byte(8'hDD);
        s_valid = 1'b0;
        wait_writes(w0 + 4, "t1");
        wait_busy(1'b0, "t1");
        check("t1_bytes_sent", bytes_sent, 32'd4);
        check("t1_fifo_level", fifo_level, 5'd0);
        check("t1_polls", poll_cnt - p0, 4);
        check("t1_data_to_spi_idle", data_to_spi, 16'h0000);

        // DREQ gating and restart latency
        dreq = 1'b0;
        cycles(3);
        a0 = acc_starts;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        s_valid = 1'b0;
        cycles(100);
        check("t2_no_access", acc_starts - a0, 0);
        check("t2_fifo_level", fifo_level, 5'd8);
        dreq = 1'b1;
        cycles(2);
        check("t2_select_early", spi_select, 1'b0);
        cycles(1);
        check("t2_select_start", spi_select, 1'b1);
        check("t2_first_addr", mem_addr, 3'd2);
        check("t2_first_read_n", read_n, 1'b0);
        wait_writes(w0 + 8, "t2");
        wait_busy(1'b0, "t2");
        check("t2_bytes_sent", bytes_sent, 32'd12);
        check("t2_fifo_level_end", fifo_level, 5'd0);

        // FIFO full, then burst limit with DREQ held high
        dreq = 1'b0;
        cycles(3);
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        s_valid = 1'b0;
        check("t3_full_level", fifo_level, 5'd16);
        check("t3_full_s_ready", s_ready, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        cycles(1);
        s_valid = 1'b0;
        check("t3_17th_rejected", fifo_level, 5'd16);
        dreq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy(1'b1, "t3_start");
            wait_busy(1'b0, "t3_end");
            check("t3_burst_writes", wr_cnt - w0, 4 * (k + 1));
        end
        check("t3_bytes_sent", bytes_sent, 32'd28);
        check("t3_fifo_level", fifo_level, 5'd0);

        // Backpressure: five polls with TRDY=0
        p0 = poll_cnt;
        w0 = wr_cnt;
        stall_until = poll_cnt + 5;
        push_byte(8'h3C);
        s_valid = 1'b0;
        wait_polls(p0 + 5, "t4");
        check("t4_no_write_while_stalled", wr_cnt - w0, 0);
        wait_writes(w0 + 1, "t4");
        wait_busy(1'b0, "t4");
        check("t4_polls", poll_cnt - p0, 6);
        check("t4_bytes_sent", bytes_sent, 32'd29);

        // RX drain between writes
        rx_mode = 1'b1;
        p0 = poll_cnt;
        w0 = wr_cnt;
        d0 = drain_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        s_valid = 1'b0;
        wait_writes(w0 + 3, "t5");
        wait_busy(1'b0, "t5");
        check("t5_drains", drain_cnt - d0, 2);
        check("t5_polls", poll_cnt - p0, 5);
        check("t5_roe", roe, 1'b0);
        check("t5_bytes_sent", bytes_sent, 32'd32);
        rx_mode = 1'b0;
        cycles(2);

        // Enable dropped during the second write of a burst
        dreq = 1'b0;
        cycles(3);
        p0 = poll_cnt;
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        s_valid = 1'b0;
        check("t6_full_level", fifo_level, 5'd16);
        dreq = 1'b1;
        begin
            int n = 0;
            while (!(write_n == 1'b0 && wr_cnt == w0 + 1) && n < 500) begin
                cycles(1);
                n++;
            end
            check("t6_second_write_seen", write_n, 1'b0);
        end
        enable = 1'b0;
        wait_busy(1'b0, "t6");
        check("t6_writes", wr_cnt - w0, 2);
        check("t6_bytes_sent", bytes_sent, 32'd34);
        check("t6_fifo_level", fifo_level, 5'd14);
        check("t6_polls", poll_cnt - p0, 2);
        a0 = acc_starts;
        cycles(10);
        check("t6_no_more_access", acc_starts - a0, 0);
        check("t6_still_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a write
        enable = 1'b1;
        begin
            int n = 0;
            while (write_n !== 1'b0 && n < 500) begin
                cycles(1);
                n++;
            end
            check("t7_write_seen", write_n, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_spi_select", spi_select, 1'b0);
        check("t7_read_n", read_n, 1'b1);
        check("t7_write_n", write_n, 1'b1);
        check("t7_mem_addr", mem_addr, 3'd0);
        check("t7_data_to_spi", data_to_spi, 16'h0000);
        check("t7_busy", busy, 1'b0);
        check("t7_fifo_level", fifo_level, 5'd0);
        check("t7_bytes_sent", bytes_sent, 32'd0);
        check("t7_s_ready", s_ready, 1'b1);
        cycles(2);
        reset_n = 1'b1;
        cycles(5);
        check("t7_idle_after_release", busy, 1'b0);

        check("protocol_errors", proto_err, 0);
        check("write_data_order", data_err, 0);
        check("idle_strobes", idle_bad, 1'b0);
        check("final_roe", roe, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
